// File: rtl/hwpe_stream_tcdm_load_credit_fifo.sv
// ---------------------------------------------------------------------------
// hwpe_stream_tcdm_load_credit_fifo
//
// TCDM load decoupler between an HWPE streamer (slave side) and the TCDM
// interconnect (master side). Load requests are buffered, issued to TCDM,
// and their responses are returned in order together with the sidechannel
// tag of the request they answer. A request is only issued when space is
// already reserved for its response, so the response path never needs
// back-pressure toward TCDM. A synchronous clear flushes all state and
// silently swallows the responses that were still in flight.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush
//   slv_req_i/slv_gnt_o    load request handshake from the streamer
//   slv_add_i/slv_sidech_i load address and tag
//   slv_r_valid_o/_ready_i response handshake toward the streamer
//   slv_r_data_o/_sidech_o response data and the tag of its request
//   mst_*                  TCDM master port (read-only usage)
//   outstanding_o          issued-but-unanswered request count
//   empty_o                nothing buffered, in flight or being dropped
// ---------------------------------------------------------------------------

// Small registered FIFO (no fall-through) with a synchronous clear.
// DEPTH need not be a power of two; pointers wrap explicitly.
module hwpe_stream_tcdm_load_credit_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_en = push & (count != CNT_W'(DEPTH));
  assign pop_en  = pop & (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
      if (push_en && !pop_en)      count <= count + CNT_W'(1);
      else if (!push_en && pop_en) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

module hwpe_stream_tcdm_load_credit_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SIDECH_WIDTH    = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               slv_req_i,
  output logic                               slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0]              slv_add_i,
  input  logic [SIDECH_WIDTH-1:0]            slv_sidech_i,
  output logic                               slv_r_valid_o,
  input  logic                               slv_r_ready_i,
  output logic [DATA_WIDTH-1:0]              slv_r_data_o,
  output logic [SIDECH_WIDTH-1:0]            slv_r_sidech_o,
  output logic                               mst_req_o,
  input  logic                               mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]              mst_add_o,
  output logic                               mst_wen_o,
  output logic [DATA_WIDTH/8-1:0]            mst_be_o,
  output logic [DATA_WIDTH-1:0]              mst_data_o,
  input  logic                               mst_r_valid_i,
  input  logic [DATA_WIDTH-1:0]              mst_r_data_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               empty_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned REQ_W = ADDR_WIDTH + SIDECH_WIDTH;
  localparam int unsigned RSP_W = DATA_WIDTH + SIDECH_WIDTH;

  logic [REQ_W-1:0]        req_rdata;
  logic [CNT_W-1:0]        req_count;
  logic [RSP_W-1:0]        resp_rdata;
  logic [CNT_W-1:0]        resp_count;
  logic [SIDECH_WIDTH-1:0] inflight_tag;
  logic [OUT_W-1:0]        outstanding;
  logic [OUT_W-1:0]        drop_cnt;
  logic                    req_empty;
  logic                    resp_empty;
  logic                    credit_ok;
  logic                    issue;
  logic                    resp_accept;
  logic                    pending;
  logic                    req_push;
  logic                    resp_pop;

  assign req_empty  = (req_count == '0);
  assign resp_empty = (resp_count == '0);
  assign slv_gnt_o  = (req_count != CNT_W'(FIFO_DEPTH));
  assign req_push   = slv_req_i & slv_gnt_o;

  hwpe_stream_tcdm_load_credit_fifo_buf #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) i_req_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (req_push),
    .wdata  ({slv_add_i, slv_sidech_i}),
    .pop    (issue),
    .rdata  (req_rdata),
    .count  (req_count)
  );

  // Outstanding responses plus buffered responses may never exceed the response
  // FIFO depth, so every response TCDM returns is guaranteed a slot.
  assign credit_ok = (SUM_W'(outstanding) + SUM_W'(resp_count)) < SUM_W'(FIFO_DEPTH);
  assign mst_req_o = ~req_empty & (outstanding < OUT_W'(MAX_OUTSTANDING)) &
                     credit_ok & (drop_cnt == '0);
  assign mst_add_o = req_empty ? '0 : req_rdata[REQ_W-1:SIDECH_WIDTH];
  assign mst_wen_o  = 1'b1;
  assign mst_be_o   = '1;
  assign mst_data_o = '0;
  assign issue      = mst_req_o & mst_gnt_i;

  assign resp_accept = mst_r_valid_i & ~clear_i & (drop_cnt == '0) & (outstanding != '0);
  assign pending     = (outstanding != '0) | (drop_cnt != '0);

  // The in-flight tag FIFO holds exactly one entry per issued request, so its
  // occupancy doubles as the outstanding counter.
  hwpe_stream_tcdm_load_credit_fifo_buf #(
    .WIDTH (SIDECH_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) i_inflight_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (issue),
    .wdata  (req_rdata[SIDECH_WIDTH-1:0]),
    .pop    (resp_accept),
    .rdata  (inflight_tag),
    .count  (outstanding)
  );

  assign resp_pop = ~resp_empty & slv_r_ready_i;

  hwpe_stream_tcdm_load_credit_fifo_buf #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) i_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (resp_accept),
    .wdata  ({mst_r_data_i, inflight_tag}),
    .pop    (resp_pop),
    .rdata  (resp_rdata),
    .count  (resp_count)
  );

  assign slv_r_valid_o  = ~resp_empty;
  assign slv_r_data_o   = resp_empty ? '0 : resp_rdata[RSP_W-1:SIDECH_WIDTH];
  assign slv_r_sidech_o = resp_empty ? '0 : resp_rdata[SIDECH_WIDTH-1:0];

  // Responses still owed by TCDM after a clear must be swallowed. A grant in the
  // clear cycle adds one more; a response arriving in the clear cycle is one of
  // those already owed and is retired immediately. While draining, issue is
  // blocked, so the sum below never exceeds MAX_OUTSTANDING.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt <= '0;
    end else if (clear_i) begin
      drop_cnt <= drop_cnt + outstanding + OUT_W'(issue) - OUT_W'(mst_r_valid_i & pending);
    end else if (mst_r_valid_i && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - OUT_W'(1);
    end
  end

  assign outstanding_o = outstanding;
  assign empty_o       = req_empty & resp_empty & (outstanding == '0) & (drop_cnt == '0);

  // A response with nothing in flight cannot be matched to a tag; it is ignored.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mst_r_valid_i && !clear_i && (outstanding == '0) && (drop_cnt == '0)));

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_credit_fifo.sv
// ---------------------------------------------------------------------------
// tb_hwpe_stream_tcdm_load_credit_fifo
//
// Bench for the TCDM load credit FIFO. A small TCDM model grants requests and
// returns data derived from the address; a scoreboard holds the response
// expected for every accepted load and compares it when the streamer side
// consumes a response.
// ---------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_load_credit_fifo;

  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int FIFO_DEPTH      = 8;
  localparam int MAX_OUTSTANDING = 4;
  localparam int SIDECH_WIDTH    = 1;
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b1;
  logic                    clear_i = 1'b0;
  logic                    slv_req_i = 1'b0;
  logic                    slv_gnt_o;
  logic [ADDR_WIDTH-1:0]   slv_add_i = '0;
  logic [SIDECH_WIDTH-1:0] slv_sidech_i = '0;
  logic                    slv_r_valid_o;
  logic                    slv_r_ready_i = 1'b1;
  logic [DATA_WIDTH-1:0]   slv_r_data_o;
  logic [SIDECH_WIDTH-1:0] slv_r_sidech_o;
  logic                    mst_req_o;
  logic                    mst_gnt_i = 1'b0;
  logic [ADDR_WIDTH-1:0]   mst_add_o;
  logic                    mst_wen_o;
  logic [DATA_WIDTH/8-1:0] mst_be_o;
  logic [DATA_WIDTH-1:0]   mst_data_o;
  logic                    mst_r_valid_i = 1'b0;
  logic [DATA_WIDTH-1:0]   mst_r_data_i = '0;
  logic [OUT_W-1:0]        outstanding_o;
  logic                    empty_o;

  hwpe_stream_tcdm_load_credit_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .SIDECH_WIDTH    (SIDECH_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .slv_req_i      (slv_req_i),
    .slv_gnt_o      (slv_gnt_o),
    .slv_add_i      (slv_add_i),
    .slv_sidech_i   (slv_sidech_i),
    .slv_r_valid_o  (slv_r_valid_o),
    .slv_r_ready_i  (slv_r_ready_i),
    .slv_r_data_o   (slv_r_data_o),
    .slv_r_sidech_o (slv_r_sidech_o),
    .mst_req_o      (mst_req_o),
    .mst_gnt_i      (mst_gnt_i),
    .mst_add_o      (mst_add_o),
    .mst_wen_o      (mst_wen_o),
    .mst_be_o       (mst_be_o),
    .mst_data_o     (mst_data_o),
    .mst_r_valid_i  (mst_r_valid_i),
    .mst_r_data_i   (mst_r_data_i),
    .outstanding_o  (outstanding_o),
    .empty_o        (empty_o)
  );

  // Free-running clock; posedges at 5, 15, 25, ... and stimulus changes on negedges.
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   add;
    logic [SIDECH_WIDTH-1:0] tag;
  } load_t;

  load_t                               load_q[$];
  logic [DATA_WIDTH+SIDECH_WIDTH-1:0]  exp_q[$];
  logic [DATA_WIDTH-1:0]               tcdm_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;

  bit gnt_on  = 1'b0;
  bit resp_on = 1'b0;
  int resp_budget = -1;

  int cyc = 0;
  int grant_cnt, rx_cnt, drops_seen, max_out;
  int last_hs_cycle, first_valid_cycle;
  logic [DATA_WIDTH-1:0]   first_valid_data;
  logic [SIDECH_WIDTH-1:0] first_valid_tag;
  int model_out, model_drop;

  bit                      prev_mst_stall, prev_resp_stall;
  logic [ADDR_WIDTH-1:0]   prev_add;
  logic [DATA_WIDTH-1:0]   prev_rdata;
  logic [SIDECH_WIDTH-1:0] prev_rtag;

  // TCDM contents: the address XOR a constant, so 0x100 reads 0xDEADBEEF.
  function automatic logic [DATA_WIDTH-1:0] memModel(input logic [ADDR_WIDTH-1:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  // Single comparison point: counts every check and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock cycle: drive from the negedge, observe handshakes 1 time unit
  // before the posedge, then advance to the next negedge.
  task automatic applyStimulus();
    logic rv, gr, hs, rpop;
    logic [DATA_WIDTH+SIDECH_WIDTH-1:0] e;
    slv_req_i     = (load_q.size() != 0);
    slv_add_i     = slv_req_i ? load_q[0].add : '0;
    slv_sidech_i  = slv_req_i ? load_q[0].tag : '0;
    mst_gnt_i     = gnt_on;
    mst_r_valid_i = resp_on && (tcdm_q.size() != 0) && (resp_budget != 0);
    mst_r_data_i  = mst_r_valid_i ? tcdm_q[0] : '0;
    #4;
    rv   = mst_r_valid_i;
    gr   = mst_req_o & mst_gnt_i;
    hs   = slv_req_i & slv_gnt_o;
    rpop = slv_r_valid_o & slv_r_ready_i;

    if (prev_mst_stall) begin
      checkOutput("mst_req_hold", mst_req_o, 1);
      checkOutput("mst_add_hold", mst_add_o, prev_add);
    end
    if (prev_resp_stall) begin
      checkOutput("resp_valid_hold", slv_r_valid_o, 1);
      checkOutput("resp_data_hold", slv_r_data_o, prev_rdata);
      checkOutput("resp_tag_hold", slv_r_sidech_o, prev_rtag);
    end
    checkOutput("outstanding", outstanding_o, model_out);
    if (model_drop > 0) checkOutput("issue_blocked", mst_req_o, 0);
    if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);

    if (slv_r_valid_o && first_valid_cycle < 0) begin
      first_valid_cycle = cyc;
      first_valid_data  = slv_r_data_o;
      first_valid_tag   = slv_r_sidech_o;
    end
    if (rpop) begin
      if (exp_q.size() == 0) begin
        checkOutput("resp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp_data", slv_r_data_o, e[DATA_WIDTH+SIDECH_WIDTH-1:SIDECH_WIDTH]);
        checkOutput("resp_tag", slv_r_sidech_o, e[SIDECH_WIDTH-1:0]);
        rx_cnt++;
      end
    end
    if (hs) begin
      last_hs_cycle = cyc;
      if (!clear_i) exp_q.push_back({memModel(slv_add_i), slv_sidech_i});
      void'(load_q.pop_front());
    end
    if (rv) begin
      void'(tcdm_q.pop_front());
      if (resp_budget > 0) resp_budget--;
    end
    if (gr) begin
      tcdm_q.push_back(memModel(mst_add_o));
      grant_cnt++;
    end

    if (clear_i) begin
      model_drop = model_drop + model_out + (gr ? 1 : 0)
                   - ((rv && (model_drop + model_out) > 0) ? 1 : 0);
      model_out  = 0;
      exp_q.delete();
    end else if (model_drop > 0) begin
      if (rv) begin
        model_drop--;
        drops_seen++;
      end
    end else begin
      model_out = model_out + (gr ? 1 : 0) - (rv ? 1 : 0);
    end

    prev_mst_stall  = mst_req_o && !mst_gnt_i && !clear_i;
    prev_add        = mst_add_o;
    prev_resp_stall = slv_r_valid_o && !slv_r_ready_i && !clear_i;
    prev_rdata      = slv_r_data_o;
    prev_rtag       = slv_r_sidech_o;

    @(negedge clk_i);
    cyc++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  // Run until every accepted load has been answered, with a cycle budget.
  task automatic waitDrain(input int bound);
    int n = 0;
    while ((load_q.size() != 0 || exp_q.size() != 0 || tcdm_q.size() != 0) && n < bound) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_done",
                (load_q.size() == 0 && exp_q.size() == 0 && tcdm_q.size() == 0), 1);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_slv_gnt"}, slv_gnt_o, 1);
    checkOutput({pfx, "_r_valid"}, slv_r_valid_o, 0);
    checkOutput({pfx, "_mst_req"}, mst_req_o, 0);
    checkOutput({pfx, "_r_data"}, slv_r_data_o, 0);
    checkOutput({pfx, "_r_sidech"}, slv_r_sidech_o, 0);
    checkOutput({pfx, "_mst_add"}, mst_add_o, 0);
    checkOutput({pfx, "_outstanding"}, outstanding_o, 0);
    checkOutput({pfx, "_empty"}, empty_o, 1);
    checkOutput({pfx, "_wen"}, mst_wen_o, 1);
    checkOutput({pfx, "_be"}, mst_be_o, 4'hF);
    checkOutput({pfx, "_wdata"}, mst_data_o, 0);
  endtask

  task automatic resetBench();
    load_q.delete();
    exp_q.delete();
    tcdm_q.delete();
    model_out       = 0;
    model_drop      = 0;
    prev_mst_stall  = 1'b0;
    prev_resp_stall = 1'b0;
    slv_req_i       = 1'b0;
    mst_r_valid_i   = 1'b0;
    mst_gnt_i       = 1'b0;
    clear_i         = 1'b0;
  endtask

  task automatic startTest();
    grant_cnt         = 0;
    rx_cnt            = 0;
    drops_seen        = 0;
    max_out           = 0;
    first_valid_cycle = -1;
    resp_budget       = -1;
  endtask

  // Safety net in case the design stalls every bounded loop.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetBench();
    startTest();
    #2 rst_ni = 1'b0;
    #1 checkResetValues("por");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] single load");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b1; slv_r_ready_i = 1'b1;
    load_q.push_back('{add: 32'h100, tag: 1'b1});
    waitDrain(40);
    checkOutput("single_latency", first_valid_cycle - last_hs_cycle, 3);
    checkOutput("single_data", first_valid_data, 32'hDEADBEEF);
    checkOutput("single_tag", first_valid_tag, 1);
    checkOutput("single_rx", rx_cnt, 1);
    checkOutput("single_outstanding", outstanding_o, 0);
    checkOutput("single_empty", empty_o, 1);

    $display("[TB] outstanding cap");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b0;
    for (int i = 0; i < 6; i++) load_q.push_back('{add: 32'h200 + 4 * i, tag: i[0]});
    runCycles(12);
    checkOutput("cap_grants", grant_cnt, 4);
    checkOutput("cap_mst_req", mst_req_o, 0);
    checkOutput("cap_outstanding", outstanding_o, 4);
    resp_on = 1'b1; resp_budget = 1;
    runCycles(4);
    checkOutput("cap_fifth_grant", grant_cnt, 5);
    checkOutput("cap_outstanding_after", outstanding_o, 4);
    resp_budget = -1;
    waitDrain(60);
    checkOutput("cap_rx", rx_cnt, 6);

    $display("[TB] credit back-pressure");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b1; slv_r_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) load_q.push_back('{add: 32'h400 + 8 * i, tag: ~i[0]});
    runCycles(30);
    checkOutput("credit_grants", grant_cnt, FIFO_DEPTH);
    checkOutput("credit_mst_req", mst_req_o, 0);
    checkOutput("credit_outstanding", outstanding_o, 0);
    checkOutput("credit_r_valid", slv_r_valid_o, 1);
    checkOutput("credit_slv_gnt", slv_gnt_o, 1);
    checkOutput("credit_rx_stalled", rx_cnt, 0);
    slv_r_ready_i = 1'b1;
    waitDrain(100);
    checkOutput("credit_rx", rx_cnt, 12);

    $display("[TB] simultaneous grant and response");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b1; slv_r_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) load_q.push_back('{add: 32'h800 + 4 * i, tag: i[1]});
    waitDrain(100);
    checkOutput("simul_grants", grant_cnt, 20);
    checkOutput("simul_rx", rx_cnt, 20);
    checkOutput("simul_max_outstanding", max_out, 1);

    $display("[TB] clear mid-flight");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b0;
    for (int i = 0; i < 3; i++) load_q.push_back('{add: 32'hA00 + 4 * i, tag: 1'b1});
    runCycles(8);
    checkOutput("clear_pre_outstanding", outstanding_o, 3);
    clear_i = 1'b1;
    applyStimulus();
    clear_i = 1'b0;
    checkOutput("clear_outstanding", outstanding_o, 0);
    checkOutput("clear_not_empty", empty_o, 0);
    checkOutput("clear_r_valid", slv_r_valid_o, 0);
    checkOutput("clear_slv_gnt", slv_gnt_o, 1);
    grant_cnt = 0;
    load_q.push_back('{add: 32'h240, tag: 1'b0});
    resp_on = 1'b1;
    waitDrain(40);
    checkOutput("clear_drops", drops_seen, 3);
    checkOutput("clear_new_grants", grant_cnt, 1);
    checkOutput("clear_new_rx", rx_cnt, 1);
    checkOutput("clear_final_empty", empty_o, 1);

    $display("[TB] async reset with traffic");
    startTest();
    gnt_on = 1'b1; resp_on = 1'b0;
    for (int i = 0; i < 2; i++) load_q.push_back('{add: 32'hC00 + 4 * i, tag: 1'b1});
    runCycles(6);
    gnt_on = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) load_q.push_back('{add: 32'hD00 + 4 * i, tag: i[0]});
    runCycles(14);
    checkOutput("rst_pre_outstanding", outstanding_o, 2);
    checkOutput("rst_pre_gnt_full", slv_gnt_o, 0);
    #2 rst_ni = 1'b0;
    #1 checkResetValues("arst");
    resetBench();
    @(negedge clk_i);
    rst_ni = 1'b1;
    startTest();
    gnt_on = 1'b1; resp_on = 1'b1; slv_r_ready_i = 1'b1;
    load_q.push_back('{add: 32'h100, tag: 1'b1});
    waitDrain(40);
    checkOutput("post_rst_latency", first_valid_cycle - last_hs_cycle, 3);
    checkOutput("post_rst_rx", rx_cnt, 1);
    checkOutput("post_rst_empty", empty_o, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_load_credit_fifo.md
Name: hwpe_stream_tcdm_load_credit_fifo

Overview:
- Parametrised TCDM load decoupler between an HWPE streamer (slave side) and the TCDM interconnect (master side).
- Buffers load requests and returns responses in order, each carrying a per-request sidechannel tag.
- Uses a credit counter that reserves response-FIFO space before issue, so responses never need back-pressure or a skid register.
- Drains in-flight responses safely across clear_i.

Parameters:
DATA_WIDTH, 32, TCDM data width.
ADDR_WIDTH, 32, TCDM address width.
FIFO_DEPTH, 8, request and response FIFO depth; power of 2, >=2.
MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests; 1..FIFO_DEPTH.
SIDECH_WIDTH, 1, sidechannel tag width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous flush
slv_req_i  in  1  load request from streamer
slv_gnt_o  out  1  request accepted
slv_add_i  in  ADDR_WIDTH  load address
slv_sidech_i  in  SIDECH_WIDTH  tag attached to request
slv_r_valid_o  out  1  response valid
slv_r_ready_i  in  1  response consumed
slv_r_data_o  out  DATA_WIDTH  response data
slv_r_sidech_o  out  SIDECH_WIDTH  tag of the request this response answers
mst_req_o  out  1  TCDM request
mst_gnt_i  in  1  TCDM grant
mst_add_o  out  ADDR_WIDTH  TCDM address
mst_wen_o  out  1  constant 1 (read)
mst_be_o  out  DATA_WIDTH/8  constant all ones
mst_data_o  out  DATA_WIDTH  constant 0
mst_r_valid_i  in  1  TCDM response valid, in order, >=1 cycle after grant
mst_r_data_i  in  DATA_WIDTH  TCDM response data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  issued-unanswered count
empty_o  out  1  fully idle

Behaviour:
- Reset: all FIFOs empty; outstanding, drop_cnt = 0. slv_gnt_o=1, slv_r_valid_o=0, mst_req_o=0, slv_r_data_o/slv_r_sidech_o/mst_add_o=0, outstanding_o=0, empty_o=1.
- Request FIFO: FIFO_DEPTH entries of {add, sidech}, no fall-through.
  - slv_gnt_o = !req_full.
  - Push on slv_req_i & slv_gnt_o.
  - Earliest mst_req_o is 1 cycle after the slave handshake.
- Issue: mst_req_o = !req_empty & (outstanding < MAX_OUTSTANDING) & (outstanding + resp_count < FIFO_DEPTH) & (drop_cnt == 0).
  - mst_req_o is never combinational on mst_gnt_i.
  - Once asserted, mst_req_o and mst_add_o stay stable until granted: credit terms only increase without a handshake.
- On mst_req_o & mst_gnt_i: pop request FIFO; push its sidech into in-flight tag FIFO (depth MAX_OUTSTANDING); outstanding++.
- On mst_r_valid_i with drop_cnt == 0:
  - Push {mst_r_data_i, in-flight head tag} into response FIFO; pop in-flight FIFO; outstanding--.
  - The push is never refused, because space is reserved at issue.
- Same-cycle grant and response: outstanding unchanged; both FIFO operations occur.
- mst_r_valid_i with outstanding==0 and drop_cnt==0: protocol violation. Response is ignored; simulation assertion fires.
- Response FIFO: depth FIFO_DEPTH, registered.
  - slv_r_valid_o = !resp_empty; pop on valid & ready.
  - Minimum latency mst_r_valid_i -> slv_r_valid_o is 1 cycle.
  - Data and tag hold stable while valid & !ready.
- clear_i (synchronous, overrides all same-cycle events):
  - Empties all three FIFOs; outstanding <= 0.
  - drop_cnt <= outstanding (plus 1 if a grant coincides with the clear).
  - While drop_cnt > 0: each mst_r_valid_i is discarded and decrements drop_cnt; issue is blocked. slv_gnt_o is still allowed.
- empty_o = req_empty & resp_empty & (outstanding==0) & (drop_cnt==0).
- Counter widths are sized so that no counter can overflow. A full request FIFO plus zero credit deasserts slv_gnt_o only; there is no deadlock as long as the consumer eventually asserts slv_r_ready_i.

Test Plan:
- Single load: addr 0x100, tag 1; grant same cycle; response 0xDEADBEEF 1 cycle later -> slv_r_valid_o at cycle 3 (slave handshake = cycle 0) with data 0xDEADBEEF, tag 1; outstanding_o returns 0; empty_o=1.
- Outstanding cap: MAX_OUTSTANDING=4; 6 requests queued; mst_r_valid_i held low -> exactly 4 grants, mst_req_o then low, outstanding_o=4; one response -> a 5th request issues.
- Credit back-pressure: FIFO_DEPTH=8; slv_r_ready_i=0; 12 loads with immediate grant and response -> exactly 8 issued, response FIFO full, no response lost; raising ready drains 12 responses in order with matching tags.
- Simultaneous events: grant and response in the same cycle over 20 back-to-back loads -> outstanding_o constant at 1; data and tags delivered in order.
- Clear mid-flight: 3 outstanding, assert clear_i -> empty FIFOs, drop_cnt=3; next 3 responses discarded; a new load issues only after the 3rd drop; its response carries the correct data and tag.
- Async reset with 2 outstanding and full FIFOs -> all outputs at reset values immediately; normal single load works after release.
